// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding imem request,
// prefetch queue toward decode, flush/redirect on taken jump or branch.
//
// Handshakes:
//   imem:   imem_req is held high with a stable imem_addr until imem_ack;
//           imem_ack is a one-cycle strobe and counts only while imem_req=1.
//   decode: instr_valid/instr_ready; the head is consumed at a rising edge
//           where both are high, and instr_valid never depends on instr_ready.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 4,
    parameter logic [15:0] PC_INC   = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [3:0]  opcode
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // IDLE: nothing outstanding; WAIT: outstanding, keep data;
    // DROP: outstanding, data belongs to a flushed path and is discarded.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   fetch_pc, fetch_pc_nxt;
    logic [15:0]   addr_q, addr_nxt;

    logic [15:0]   q_data [DEPTH];
    logic [15:0]   q_pc   [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;

    logic          ack_ok;
    logic          push;
    logic          pop;
    logic          issue;

    assign ack_ok      = imem_ack && imem_req;
    assign instr_valid = (count != '0);
    // A redirect discards the head, so a pop in that cycle does not happen.
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    // Occupancy after this cycle's push (WAIT+ack) and pop, used to decide
    // whether another request still fits.
    assign count_after = count + CW'(1) - CW'(pop);

    assign imem_req  = (state != S_IDLE);
    assign imem_addr = addr_q;
    assign instr     = instr_valid ? q_data[rd_ptr] : 16'h0000;
    assign instr_pc  = instr_valid ? q_pc[rd_ptr]   : 16'h0000;
    assign opcode    = instr[15:12];

    // FSM state, fetch PC and latched request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            addr_q   <= addr_nxt;
        end
    end

    // Next-state logic: redirect first, then response handling, then issue.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        addr_nxt     = addr_q;
        push         = 1'b0;
        issue        = 1'b0;
        case (state)
            S_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redirect_pc;
                end else if (count < DEPTH_C) begin
                    issue = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redirect_pc;
                    state_nxt    = ack_ok ? S_IDLE : S_DROP;
                end else if (ack_ok) begin
                    push = 1'b1;
                    if (count_after < DEPTH_C) begin
                        issue = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redirect_pc;
                end
                if (ack_ok) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (issue) begin
            state_nxt    = S_WAIT;
            addr_nxt     = fetch_pc;
            fetch_pc_nxt = fetch_pc + PC_INC;
        end
    end

    // Queue pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage: word and its PC written together at the push slot.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= addr_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-configurable memory
// model and a scoreboard of expected {instr, instr_pc} pairs.
module tb_instr_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [3:0]  opcode;

    // clock
    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (4),
        .PC_INC  (16'd2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .opcode        (opcode)
    );

    // scoreboard: {instr, instr_pc}
    logic [31:0] exp_q[$];
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          mem_lat   = 0;
    int          req_age   = 0;
    int          ack_count = 0;
    logic        cont      = 1'b0;
    logic        dropped   = 1'b0;
    logic        stray     = 1'b0;
    logic        seen_a123 = 1'b0;
    logic [15:0] next_exp_addr = RESET_PC;
    logic [15:0] held_addr     = RESET_PC;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'hFFFE) ? 16'hA123 : a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    // One cycle: drive memory response, check outputs, update model, advance.
    task automatic step();
        logic [31:0] head;
        logic        new_req;
        imem_ack   = stray || ((imem_req === 1'b1) && (req_age >= mem_lat));
        imem_rdata = (imem_ack && !stray) ? mem_word(imem_addr) : 16'($urandom_range(0, 65535));
        if (!rst) begin
            new_req = imem_req && !cont;
            if (new_req) begin
                chk("issue_addr", imem_addr, next_exp_addr);
                held_addr     = imem_addr;
                next_exp_addr = next_exp_addr + 16'd2;
            end else if (imem_req) begin
                chk("addr_hold", imem_addr, held_addr);
            end
            chk("instr_valid", instr_valid, exp_q.size() != 0);
            if (exp_q.size() == 0) begin
                chk("empty_instr", instr, 0);
                chk("empty_pc", instr_pc, 0);
                chk("empty_opcode", opcode, 0);
            end else if (instr_ready && !redirect_valid) begin
                head = exp_q.pop_front();
                chk("instr", instr, head[31:16]);
                chk("instr_pc", instr_pc, head[15:0]);
                chk("opcode", opcode, head[31:28]);
                if (head[31:16] == 16'hA123 && opcode === 4'hA) seen_a123 = 1'b1;
            end
        end
        if (rst) begin
            exp_q.delete();
            next_exp_addr = RESET_PC;
            dropped       = 1'b0;
            req_age       = 0;
            cont          = 1'b0;
        end else begin
            if (imem_ack && imem_req) begin
                ack_count++;
                if (!dropped && !redirect_valid) exp_q.push_back({mem_word(imem_addr), imem_addr});
                dropped = 1'b0;
                req_age = 0;
            end else if (imem_req) begin
                req_age++;
                if (redirect_valid) dropped = 1'b1;
            end
            if (redirect_valid) begin
                exp_q.delete();
                next_exp_addr = redirect_pc;
            end
            cont = imem_req && !imem_ack;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic run_until_req(input logic [15:0] a, input int max);
        bit found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            if (imem_req && !cont && imem_addr == a) found = 1'b1;
            else step();
        end
        if (!found) timeout("wait_req");
    endtask

    task automatic redirect(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = 16'h0000;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        instr_ready    = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", instr_valid, 0);

        // zero-wait streaming
        mem_lat     = 0;
        instr_ready = 1'b1;
        repeat (20) step();

        // fill to DEPTH with decode stalled, then drain
        do_reset();
        instr_ready = 1'b0;
        ack_count   = 0;
        repeat (12) step();
        chk("acks_at_full", 32'(ack_count), 4);
        chk("req_idle_full", imem_req, 0);
        instr_ready = 1'b1;
        repeat (10) step();

        // redirect while a slow request is outstanding
        do_reset();
        mem_lat     = 2;
        instr_ready = 1'b1;
        run_until_req(16'h0004, 50);
        chk("slow_req_age", 32'(req_age), 0);
        redirect(16'h0100);
        repeat (30) step();

        // redirect coincident with ack and pop
        mem_lat = 0;
        repeat (5) step();
        chk("coinc_valid", instr_valid, 1);
        chk("coinc_req", imem_req, 1);
        redirect(16'h0200);
        repeat (10) step();

        // wrap-around of the PC and opcode extraction
        redirect(16'hFFFC);
        repeat (10) step();
        chk("saw_a123", seen_a123, 1);

        // reset while waiting with two queued entries
        do_reset();
        mem_lat     = 2;
        instr_ready = 1'b0;
        for (int i = 0; i < 50 && !(exp_q.size() == 2 && imem_req); i++) step();
        if (!(exp_q.size() == 2 && imem_req)) timeout("fill_two");
        do_reset();
        chk("rst2_valid", instr_valid, 0);
        chk("rst2_req", imem_req, 0);
        chk("rst2_addr", imem_addr, RESET_PC);
        stray = 1'b1;
        step();
        stray = 1'b0;
        chk("stray_valid", instr_valid, 0);
        mem_lat     = 0;
        instr_ready = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
